// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: start, DW data bits LSB first, optional parity, 1-2 stop bits.
// tx lags each tick by one clk; start is ignored while ready = 0 (no queueing).
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DW        = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          tx
);

  if (DW < 5 || DW > 8) begin : g_bad_dw
    $error("uart_tx_tick: DW must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_tick: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_tick: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_IDX  = 3'(DW - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t        state, state_n;
  logic [DW-1:0] shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          stop_cnt, stop_cnt_n;
  logic          par_bit, par_bit_n;
  logic          tx_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      ready    <= 1'b1;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_bit_n;
      tx       <= tx_n;
      ready    <= (state_n == IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    par_bit_n  = par_bit;

    case (state)
      IDLE: begin
        // A tick coinciding with acceptance is deliberately dropped; SYNC waits for the next one.
        if (start) begin
          state_n    = SYNC;
          shreg_n    = data;
          par_bit_n  = (PARITY == PAR_ODD) ? ~^data : ^data;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
        end
      end
      SYNC: begin
        if (tick) state_n = START;
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == LAST_IDX) begin
            bit_idx_n = '0;
            state_n   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_n    = IDLE;
            stop_cnt_n = 1'b0;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx is a pure register output.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:            tx_n = 1'b0;
      DATA:             tx_n = shreg_n[0];
      uart_pkg::PARITY: tx_n = par_bit_n;
      default:          tx_n = 1'b1;
    endcase
  end

endmodule
